div32_seq: RTL
==============

# div32_seq

Multi-cycle 32-bit restoring divider: the iterative counterpart to the single-cycle ALU's add/sub datapath. It produces quotient and remainder for the DIV/DIVU instruction path. The pipeline launches an operation with a one-cycle start pulse, stalls on `busy`, and collects results on the `ready` pulse. Each of the 32 iterations is a shift followed by a trial subtract, so a full divide takes a fixed 32 steps.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported; the iteration counter is sized `$clog2(WIDTH)+1`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  launch request; sampled only while idle.
- `sign`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`.
- `a`  in  32  dividend; sampled with `start`.
- `b`  in  32  divisor; sampled with `start`.
- `q`  out  32  quotient; valid from the `ready` pulse until the next accepted start.
- `r`  out  32  remainder; same validity as `q`.
- `busy`  out  1  high while iterating.
- `ready`  out  1  one-cycle completion pulse.
- `dz`  out  1  divide-by-zero flag; valid with `q`/`r`.

## Operation
- **FSM states:** IDLE → RUN → DONE → IDLE.
  - IDLE: `start`=1 latches operands, clears the counter, and goes to RUN.
  - RUN: performs one iteration per cycle; after the 32nd iteration goes to DONE.
  - DONE: asserts `ready` for one cycle, then returns to IDLE. A `start` seen in DONE is ignored.
- **Operand preparation at start:**
  - Signed mode: take magnitudes, |a| and |b|.
  - Record `negq` = a[31]^b[31] and `negr` = a[31].
  - Unsigned mode: `negq` = `negr` = 0.
- **Iteration** (33-bit partial remainder `pr`, 32-bit shift register `qs`):
  - `{pr,qs}` ← `{pr,qs}` << 1.
  - t = pr − {1'b0, |b|}.
  - If t ≥ 0: `pr` ← t and `qs[0]` ← 1; otherwise `qs[0]` ← 0.
- **Finalise on entry to DONE:**
  - `q` = `negq` ? −`qs` : `qs`.
  - `r` = `negr` ? −`pr[31:0]` : `pr[31:0]`.
  - All arithmetic is modulo 2^32.
- **Divide by zero (b = 0):**
  - Still takes the full latency.
  - `q` = 32'hFFFF_FFFF, `r` = a (the original, unmodified), `dz` = 1.
  - Sign correction is not applied.
- **Signed overflow:** −2^31 / −1 gives `q` = 32'h8000_0000, `r` = 0, `dz` = 0.
- **Result stability:** `q`, `r` and `dz` hold their last values through IDLE and change only on entry to DONE.
- **Start while busy or in DONE:** ignored; no queueing.

## Timing
- **Start edge (E0):** `start` is sampled high in IDLE. After E0, `busy` = 1.
- **Iteration edges:** E1..E32 perform iterations 1..32.
- **Completion edge (E33):** `busy` = 0, `ready` = 1, and `q`/`r`/`dz` are updated.
- **Return edge (E34):** `ready` = 0. A new `start` is accepted no earlier than E34.
- **Latency:** 33 cycles from the start edge to `ready`. Throughput is one divide per 34 cycles.
- **Reset:**
  - `rst` has priority over `start`.
  - On any edge with `rst` = 1: state → IDLE; `busy`, `ready`, `dz` = 0; `q`, `r` = 0; counter = 0.
  - Reset mid-RUN aborts the operation; no `ready` is produced.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `DIV32_SIGNED_EN`.
- **Defined:**
  - `sign` is honoured.
  - Magnitude pre-conversion and post-negation logic are present, with behaviour as above.
- **Undefined:**
  - `sign` is ignored and every operation is unsigned.
  - The negators are removed.
  - Latency is unchanged at 33 cycles.
  - A start with `sign` = 1 produces the DIVU result.

## Test plan
- **Unsigned basic:** `sign`=0, a=100, b=7 → `ready` at start+33, `q`=14, `r`=2, `dz`=0, `busy` high for exactly 33 cycles.
- **Signed signs** (`DIV32_SIGNED_EN` defined):
  - a=−7 (32'hFFFF_FFF9), b=2 → `q`=−3 (32'hFFFF_FFFD), `r`=−1 (32'hFFFF_FFFF).
  - a=7, b=−2 → `q`=−3, `r`=1.
- **Divide by zero:** a=32'h1234_5678, b=0 → `q`=32'hFFFF_FFFF, `r`=32'h1234_5678, `dz`=1, same latency.
- **Overflow and unsigned extreme:**
  - Signed a=32'h8000_0000, b=32'hFFFF_FFFF → `q`=32'h8000_0000, `r`=0.
  - Unsigned with the same operands → `q`=0, `r`=32'h8000_0000.
- **Handshake:**
  - A `start` pulse with new operands at start+10 is ignored; the first result is intact.
  - Back-to-back `start` at E34 is accepted, and its `ready` arrives at E67.
- **Reset mid-operation:** `rst` at start+15 → next cycle `busy`=0, `q`=`r`=0, no `ready` within the following 40 cycles. A subsequent divide of 9/3 returns `q`=3, `r`=0.

Source files
------------

// File: rtl/div32_seq.sv
// div32_seq -- multi-cycle restoring divider for the DIV/DIVU path.
//
// Each launch performs WIDTH shift/trial-subtract steps on magnitudes. One
// extra cycle then applies the sign correction and the divide-by-zero
// override. `ready` pulses 33 cycles after the start edge. A new start is
// accepted on the edge that ends the ready pulse, so the throughput is one
// divide every 34 cycles.
//
// Optional feature macro: DIV32_SIGNED_EN
//   defined   : `sign` selects signed (DIV) or unsigned (DIVU) operation
//   undefined : `sign` is ignored and every operation is unsigned
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active high, has priority over start
//   start  in   launch request, sampled only in IDLE
//   sign   in   1 = signed, 0 = unsigned, sampled with start
//   a      in   dividend, sampled with start
//   b      in   divisor, sampled with start
//   q      out  quotient, held until the next completion
//   r      out  remainder, held until the next completion
//   busy   out  high from the start edge until completion
//   ready  out  one-cycle completion pulse
//   dz     out  divide-by-zero flag, valid with q/r
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; results hold their last values
// RUN   | one shift/trial-subtract iteration per cycle (WIDTH cycles)
// DONE  | finalise sign/dz, pulse ready, return to IDLE
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             ready,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   pr;       // partial remainder
    logic [WIDTH-1:0] qs;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] a_orig;   // raw dividend, returned as r on divide by zero
    logic             dz_op;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [2*WIDTH:0] sh;
    logic [WIDTH:0]   pr_sh;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef DIV32_SIGNED_EN
    logic negq;
    logic negr;
    logic negq_in;
    logic negr_in;
`else
    logic unused_sign;
    assign unused_sign = sign;
`endif

    // Operand preparation at start
    always_comb begin
        a_mag = a;
        b_mag = b;
`ifdef DIV32_SIGNED_EN
        negq_in = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
        negr_in = sign & a[WIDTH-1];
        if (sign && a[WIDTH-1]) a_mag = -a;
        if (sign && b[WIDTH-1]) b_mag = -b;
`endif
    end

    // One restoring step: shift {pr,qs} left, then keep the subtraction if it
    // did not go negative.
    always_comb begin
        sh    = {pr, qs} << 1;
        pr_sh = sh[2*WIDTH:WIDTH];
        trial = pr_sh - {1'b0, dvs};
        fits  = (pr_sh >= {1'b0, dvs});
    end

    // Result correction applied on the completion edge
    always_comb begin
        q_fin = qs;
        r_fin = pr[WIDTH-1:0];
`ifdef DIV32_SIGNED_EN
        if (negq) q_fin = -qs;
        if (negr) r_fin = -pr[WIDTH-1:0];
`endif
        // Divide by zero overrides everything, with no sign correction
        if (dz_op) begin
            q_fin = '1;
            r_fin = a_orig;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pr     <= '0;
            qs     <= '0;
            dvs    <= '0;
            a_orig <= '0;
            dz_op  <= 1'b0;
            q      <= '0;
            r      <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            dz     <= 1'b0;
`ifdef DIV32_SIGNED_EN
            negq   <= 1'b0;
            negr   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        pr     <= '0;
                        qs     <= a_mag;
                        dvs    <= b_mag;
                        a_orig <= a;
                        dz_op  <= (b == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
`ifdef DIV32_SIGNED_EN
                        negq   <= negq_in;
                        negr   <= negr_in;
`endif
                    end
                end
                S_RUN: begin
                    pr  <= fits ? trial : pr_sh;
                    qs  <= {sh[WIDTH-1:1], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    q     <= q_fin;
                    r     <= r_fin;
                    dz    <= dz_op;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
